// File: rtl/ldtu_pkg.sv
// Shared definitions for the LDTU baseline calibration block: FSM encoding and widths.
package ldtu_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        ACCUM   = 3'd2,
        COMPUTE = 3'd3,
        DONE    = 3'd4
    } bsl_state_t;

    localparam int Nbits_12 = 12;
    localparam int Nbits_8  = 8;

    localparam logic [Nbits_8-1:0] BSL_MAX = 8'hFF;

endpackage

// File: rtl/ldtu_bsl_acc.sv
// Per-gain pedestal accumulator: sums samples, then averages, removes the margin and clamps to 8 bits.
module ldtu_bsl_acc
    import ldtu_pkg::*;
#(
    parameter int NSAMP_LOG2 = 6,
    parameter int MARGIN     = 2
) (
    input  logic                CLK,
    input  logic                rst,
    input  logic                clr,
    input  logic                en,
    input  logic [Nbits_12-1:0] din,
    input  logic                calc,
    output logic [Nbits_8-1:0]  bsl,
    output logic                sat
);

    localparam int AW = Nbits_12 + NSAMP_LOG2;
    localparam int VW = Nbits_12 + 2;
    localparam logic signed [VW-1:0] MARG    = VW'(MARGIN);
    localparam logic signed [VW-1:0] VMAX    = VW'(BSL_MAX);

    logic [AW-1:0]              acc;
    logic [Nbits_12-1:0]        avg;
    logic signed [VW-1:0]       v;
    logic                       clamp;

    assign avg = acc[AW-1:NSAMP_LOG2];
    // Two extra bits give a sign bit plus headroom, so avg-MARGIN can go negative cleanly.
    assign v   = $signed({2'b00, avg}) - MARG;

    always_comb begin
        bsl   = v[Nbits_8-1:0];
        clamp = 1'b0;
        if (v < 0) begin
            bsl   = '0;
            clamp = 1'b1;
        end else if (v > VMAX) begin
            bsl   = BSL_MAX;
            clamp = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            acc <= '0;
            sat <= 1'b0;
        end else begin
            if (clr) begin
                acc <= '0;
                sat <= 1'b0;
            end else if (en) begin
                acc <= acc + AW'(din);
            end
            if (calc)
                sat <= clamp;
        end
    end

endmodule

// File: rtl/ldtu_bsl_calib.sv
// Baseline calibration controller: settle, average pedestals on both gains, publish BSL_VAL words.
// Optional feature: LDTU_BSL_OVERRIDE_EN adds direct slow-control override of the BSL_VAL words.
module ldtu_bsl_calib
    import ldtu_pkg::*;
#(
    parameter int NSAMP_LOG2 = 6,
    parameter int SETTLE_CYC = 16,
    parameter int MARGIN     = 2
) (
    input  logic                CLK,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic                samp_valid,
    input  logic [Nbits_12-1:0] DATA12_g01,
    input  logic [Nbits_12-1:0] DATA12_g10,
`ifdef LDTU_BSL_OVERRIDE_EN
    input  logic                ovr_en,
    input  logic [Nbits_8-1:0]  ovr_g01,
    input  logic [Nbits_8-1:0]  ovr_g10,
`endif
    output logic [Nbits_8-1:0]  BSL_VAL_g01,
    output logic [Nbits_8-1:0]  BSL_VAL_g10,
    output logic                busy,
    output logic                done,
    output logic                sat_g01,
    output logic                sat_g10
);

    localparam int SCW   = $clog2(SETTLE_CYC + 1);
    localparam int CW    = NSAMP_LOG2 + 1;
    localparam logic [CW-1:0]  LAST_SAMP = CW'((1 << NSAMP_LOG2) - 1);
    localparam logic [SCW-1:0] SETTLE_LD = SCW'(SETTLE_CYC - 1);

    bsl_state_t          state;
    logic [SCW-1:0]      settle_cnt;
    logic [CW-1:0]       samp_cnt;
    logic                ovr, kill, clr, en, calc;
    logic [Nbits_8-1:0]  bsl_g01, bsl_g10;

`ifdef LDTU_BSL_OVERRIDE_EN
    assign ovr = ovr_en;
`else
    assign ovr = 1'b0;
`endif

    // Override behaves exactly like a held abort on the calibration sequence.
    assign kill = abort | ovr;
    assign clr  = (state == IDLE) && start && !kill;
    assign en   = (state == ACCUM) && samp_valid && !kill;
    assign calc = (state == COMPUTE) && !kill;

    ldtu_bsl_acc #(.NSAMP_LOG2(NSAMP_LOG2), .MARGIN(MARGIN)) u_acc_g01 (
        .CLK(CLK), .rst(rst), .clr(clr), .en(en), .din(DATA12_g01),
        .calc(calc), .bsl(bsl_g01), .sat(sat_g01)
    );

    ldtu_bsl_acc #(.NSAMP_LOG2(NSAMP_LOG2), .MARGIN(MARGIN)) u_acc_g10 (
        .CLK(CLK), .rst(rst), .clr(clr), .en(en), .din(DATA12_g10),
        .calc(calc), .bsl(bsl_g10), .sat(sat_g10)
    );

    always_ff @(posedge CLK) begin
        if (rst) begin
            BSL_VAL_g01 <= '0;
            BSL_VAL_g10 <= '0;
`ifdef LDTU_BSL_OVERRIDE_EN
        end else if (ovr_en) begin
            BSL_VAL_g01 <= ovr_g01;
            BSL_VAL_g10 <= ovr_g10;
`endif
        end else if (calc) begin
            BSL_VAL_g01 <= bsl_g01;
            BSL_VAL_g10 <= bsl_g10;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            settle_cnt <= '0;
            samp_cnt   <= '0;
        end else begin
            done <= 1'b0;
            if (kill) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        state      <= SETTLE;
                        busy       <= 1'b1;
                        settle_cnt <= SETTLE_LD;
                        samp_cnt   <= '0;
                    end
                    SETTLE: begin
                        if (settle_cnt == '0)
                            state <= ACCUM;
                        else
                            settle_cnt <= settle_cnt - 1'b1;
                    end
                    ACCUM: if (samp_valid) begin
                        samp_cnt <= samp_cnt + 1'b1;
                        if (samp_cnt == LAST_SAMP)
                            state <= COMPUTE;
                    end
                    COMPUTE: begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ldtu_bsl_calib.sv
// Directed bench for ldtu_bsl_calib; cycle 1 is the cycle in which start is driven high.
module tb_ldtu_bsl_calib;

    logic        CLK = 1'b0;
    logic        rst, start, abort, samp_valid;
    logic [11:0] DATA12_g01, DATA12_g10;
    logic [7:0]  BSL_VAL_g01, BSL_VAL_g10;
    logic        busy, done, sat_g01, sat_g10;
`ifdef LDTU_BSL_OVERRIDE_EN
    logic        ovr_en;
    logic [7:0]  ovr_g01, ovr_g10;
`endif

    int checks   = 0;
    int failures = 0;
    int n;
    int seen;

    always #5 CLK = ~CLK;

    ldtu_bsl_calib dut (
        .CLK(CLK), .rst(rst), .start(start), .abort(abort), .samp_valid(samp_valid),
        .DATA12_g01(DATA12_g01), .DATA12_g10(DATA12_g10),
`ifdef LDTU_BSL_OVERRIDE_EN
        .ovr_en(ovr_en), .ovr_g01(ovr_g01), .ovr_g10(ovr_g10),
`endif
        .BSL_VAL_g01(BSL_VAL_g01), .BSL_VAL_g10(BSL_VAL_g10),
        .busy(busy), .done(done), .sat_g01(sat_g01), .sat_g10(sat_g10)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // mode 0: samp_valid always high; mode 1: samp_valid follows the cycle parity, plus a stray start at cycle 60
    task automatic run_cal(input int mode, input int limit, output int cyc);
        cyc = 1;
        @(negedge CLK);
        start = 1'b1;
        samp_valid = (mode == 0) ? 1'b1 : 1'(cyc & 1);
        while (done !== 1'b1 && cyc < limit) begin
            @(negedge CLK);
            cyc++;
            start = (mode == 1 && cyc == 60);
            samp_valid = (mode == 0) ? 1'b1 : 1'(cyc & 1);
        end
        start = 1'b0;
    endtask

    // drive a run with samp_valid=1 and hit it with abort (or rst) in cycle at_cyc
    task automatic run_kill(input int at_cyc, input bit use_rst, output int dseen);
        dseen = 0;
        @(negedge CLK);
        start = 1'b1;
        samp_valid = 1'b1;
        for (int c = 2; c <= at_cyc; c++) begin
            @(negedge CLK);
            start = 1'b0;
            if (done === 1'b1) dseen++;
        end
        if (use_rst) rst = 1'b1;
        else abort = 1'b1;
        @(negedge CLK);
        rst = 1'b0;
        abort = 1'b0;
    endtask

    task automatic watch_done(input int cycles, inout int dseen);
        for (int c = 0; c < cycles; c++) begin
            @(negedge CLK);
            if (done === 1'b1) dseen++;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; samp_valid = 1'b0;
        DATA12_g01 = 12'd100; DATA12_g10 = 12'd40;
`ifdef LDTU_BSL_OVERRIDE_EN
        ovr_en = 1'b0; ovr_g01 = 8'h00; ovr_g10 = 8'h00;
`endif
        repeat (3) @(negedge CLK);
        rst = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_bsl_g01", 32'(BSL_VAL_g01), 0);
        check("rst_bsl_g10", 32'(BSL_VAL_g10), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_sat_g01", 32'(sat_g01), 0);
        check("rst_sat_g10", 32'(sat_g10), 0);

        // nominal pedestals: 100-2=98, 40-2=38
        run_cal(0, 300, n);
        check("s2_latency", 32'(n), 83);
        check("s2_bsl_g01", 32'(BSL_VAL_g01), 98);
        check("s2_bsl_g10", 32'(BSL_VAL_g10), 38);
        check("s2_sat_g01", 32'(sat_g01), 0);
        check("s2_sat_g10", 32'(sat_g10), 0);
        @(negedge CLK);
        check("s2_done_pulse", 32'(done), 0);
        check("s2_busy_after", 32'(busy), 0);

        // clamps: 1-2<0 -> 0, 600-2>255 -> 255
        DATA12_g01 = 12'd1; DATA12_g10 = 12'd600;
        run_cal(0, 300, n);
        check("s3_latency", 32'(n), 83);
        check("s3_bsl_g01", 32'(BSL_VAL_g01), 0);
        check("s3_bsl_g10", 32'(BSL_VAL_g10), 255);
        check("s3_sat_g01", 32'(sat_g01), 1);
        check("s3_sat_g10", 32'(sat_g10), 1);
        @(negedge CLK);

        // every other cycle valid: 128 ACCUM cycles -> 1+16+128+2
        DATA12_g01 = 12'd100; DATA12_g10 = 12'd40;
        run_cal(1, 400, n);
        check("s4_latency", 32'(n), 147);
        check("s4_bsl_g01", 32'(BSL_VAL_g01), 98);
        check("s4_bsl_g10", 32'(BSL_VAL_g10), 38);
        check("s4_sat_g01", 32'(sat_g01), 0);
        check("s4_sat_g10", 32'(sat_g10), 0);
        @(negedge CLK);
        samp_valid = 1'b0;
        @(negedge CLK);

        // abort together with sample 30 (cycle 47)
        DATA12_g01 = 12'd7; DATA12_g10 = 12'd9;
        run_kill(47, 1'b0, seen);
        check("s5_abort_busy", 32'(busy), 0);
        watch_done(120, seen);
        check("s5_abort_nodone", 32'(seen), 0);
        check("s5_abort_g01", 32'(BSL_VAL_g01), 98);
        check("s5_abort_g10", 32'(BSL_VAL_g10), 38);

        // abort together with the last sample (cycle 81)
        run_kill(81, 1'b0, seen);
        check("last_abort_busy", 32'(busy), 0);
        watch_done(20, seen);
        check("last_abort_nodone", 32'(seen), 0);
        check("last_abort_g01", 32'(BSL_VAL_g01), 98);

        // abort and start together in IDLE
        @(negedge CLK);
        start = 1'b1; abort = 1'b1;
        @(negedge CLK);
        start = 1'b0; abort = 1'b0;
        check("idle_abort_busy", 32'(busy), 0);
        seen = 0;
        watch_done(100, seen);
        check("idle_abort_nodone", 32'(seen), 0);
        check("idle_abort_busy2", 32'(busy), 0);

        // reset mid-accumulation clears the published words
        run_kill(47, 1'b1, seen);
        check("s5_rst_busy", 32'(busy), 0);
        check("s5_rst_g01", 32'(BSL_VAL_g01), 0);
        check("s5_rst_g10", 32'(BSL_VAL_g10), 0);
        watch_done(120, seen);
        check("s5_rst_nodone", 32'(seen), 0);

`ifdef LDTU_BSL_OVERRIDE_EN
        // override during ACCUM aborts and forces the words
        DATA12_g01 = 12'd100; DATA12_g10 = 12'd40;
        seen = 0;
        @(negedge CLK);
        start = 1'b1;
        samp_valid = 1'b1;
        for (int c = 2; c <= 30; c++) begin
            @(negedge CLK);
            start = 1'b0;
        end
        ovr_en = 1'b1; ovr_g01 = 8'h55; ovr_g10 = 8'h2A;
        @(negedge CLK);
        check("ovr_g01", 32'(BSL_VAL_g01), 32'h55);
        check("ovr_g10", 32'(BSL_VAL_g10), 32'h2A);
        check("ovr_busy", 32'(busy), 0);
        ovr_en = 1'b0; ovr_g01 = 8'h11; ovr_g10 = 8'h22;
        watch_done(100, seen);
        check("ovr_hold_g01", 32'(BSL_VAL_g01), 32'h55);
        check("ovr_hold_g10", 32'(BSL_VAL_g10), 32'h2A);
        check("ovr_nodone", 32'(seen), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
